// File: rtl/cfg_req_initiator_if.sv
// Command, response and config-bus signals of the requester. req layout (MSB first):
// valid, opcode[3:0], addr[47:0], be[7:0], data[63:0], sai[7:0], fid[7:0], bar[2:0].
// ack layout (MSB first): write_valid, read_valid, data[63:0], read_miss, write_miss, sai_successfull.
interface cfg_req_initiator_if;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_opcode;
    logic [47:0]   cmd_addr;
    logic [7:0]    cmd_be;
    logic [63:0]   cmd_data;
    logic [7:0]    cmd_sai;
    logic [7:0]    cmd_fid;
    logic [2:0]    cmd_bar;
    logic [143:0]  req;
    logic [68:0]   ack;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_data;
    logic [2:0]    rsp_status;

    // Environment side: local master plus register target.
    modport master (
        output cmd_valid, cmd_opcode, cmd_addr, cmd_be, cmd_data, cmd_sai, cmd_fid, cmd_bar,
        input  cmd_ready,
        input  req,
        output ack,
        input  rsp_valid, rsp_data, rsp_status,
        output rsp_ready
    );

    // Requester side.
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_addr, cmd_be, cmd_data, cmd_sai, cmd_fid, cmd_bar,
        output cmd_ready,
        output req,
        input  ack,
        output rsp_valid, rsp_data, rsp_status,
        input  rsp_ready
    );
endinterface

// File: rtl/cfg_req_initiator.sv
// Config-bus requester: one command in flight, single-beat request, ack/timeout
// resolution into a status-coded response, and a saturating stray-ack counter.
module cfg_req_initiator #(
    parameter  int TIMEOUT = 256,
    localparam int TMR_W   = $clog2(TIMEOUT) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cfg_req_initiator_if.slave   bus,
    output logic [7:0]           stray_ack_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_MISS    = 3'd1;
    localparam logic [2:0] ST_SAIFAIL = 3'd2;
    localparam logic [2:0] ST_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_PROTO   = 3'd4;
    localparam logic [2:0] ST_ILLEGAL = 3'd5;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]       state_reg, state_next;
    logic [143:0]     req_reg;
    logic             is_write_reg;
    logic [TMR_W-1:0] timer_reg;
    logic             rsp_valid_reg;
    logic [63:0]      rsp_data_reg;
    logic [2:0]       rsp_status_reg;
    logic [7:0]       stray_reg;

    logic        ack_wv, ack_rv, ack_rm, ack_wm, ack_sai;
    logic [63:0] ack_data;
    logic        any_ack, exp_valid, exp_miss, opp_class;
    logic        accept, illegal, timer_expired;
    logic [2:0]  res_status;
    logic [63:0] res_data;

    assign ack_wv   = bus.ack[68];
    assign ack_rv   = bus.ack[67];
    assign ack_data = bus.ack[66:3];
    assign ack_rm   = bus.ack[2];
    assign ack_wm   = bus.ack[1];
    assign ack_sai  = bus.ack[0];
    assign any_ack  = ack_wv | ack_rv | ack_rm | ack_wm;

    assign exp_valid = is_write_reg ? ack_wv : ack_rv;
    assign exp_miss  = is_write_reg ? ack_wm : ack_rm;
    assign opp_class = is_write_reg ? (ack_rv | ack_rm) : (ack_wv | ack_wm);

    assign bus.cmd_ready  = (state_reg == S_IDLE) && rst_n;
    assign accept         = bus.cmd_valid && bus.cmd_ready;
    assign illegal        = bus.cmd_opcode[3];
    assign timer_expired  = (timer_reg == TMR_LAST);

    assign bus.req        = req_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_data   = rsp_data_reg;
    assign bus.rsp_status = rsp_status_reg;
    assign stray_ack_cnt  = stray_reg;

    // Priority-ordered ack resolution; only meaningful while any_ack is set in WAIT.
    always_comb begin
        res_status = ST_OK;
        res_data   = 64'd0;
        if ((exp_valid && exp_miss) || opp_class) begin
            res_status = ST_PROTO;
        end else if (exp_miss) begin
            res_status = ST_MISS;
        end else if (!ack_sai) begin
            res_status = ST_SAIFAIL;
        end else begin
            res_status = ST_OK;
            res_data   = is_write_reg ? 64'd0 : ack_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = illegal ? S_RESP : S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (any_ack || timer_expired) state_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            req_reg        <= '0;
            is_write_reg   <= 1'b0;
            timer_reg      <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= 64'd0;
            rsp_status_reg <= 3'd0;
            stray_reg      <= 8'd0;
        end else begin
            state_reg <= state_next;

            if (any_ack && (state_reg != S_WAIT) && (stray_reg != 8'd255))
                stray_reg <= stray_reg + 8'd1;

            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        is_write_reg <= bus.cmd_opcode[0];
                        // Illegal commands still latch their fields but never raise valid.
                        req_reg <= {~illegal, bus.cmd_opcode, bus.cmd_addr, bus.cmd_be,
                                    bus.cmd_data, bus.cmd_sai, bus.cmd_fid, bus.cmd_bar};
                        if (illegal) begin
                            rsp_valid_reg  <= 1'b1;
                            rsp_status_reg <= ST_ILLEGAL;
                            rsp_data_reg   <= 64'd0;
                        end
                    end
                end
                S_ISSUE: begin
                    req_reg[143] <= 1'b0;
                    timer_reg    <= '0;
                end
                S_WAIT: begin
                    timer_reg <= timer_reg + TMR_W'(1);
                    if (any_ack) begin
                        rsp_valid_reg  <= 1'b1;
                        rsp_status_reg <= res_status;
                        rsp_data_reg   <= res_data;
                    end else if (timer_expired) begin
                        rsp_valid_reg  <= 1'b1;
                        rsp_status_reg <= ST_TIMEOUT;
                        rsp_data_reg   <= 64'd0;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg  <= 1'b0;
                        rsp_status_reg <= 3'd0;
                        rsp_data_reg   <= 64'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_req_initiator.sv
// Self-checking bench for cfg_req_initiator: scoreboard of expected responses
// plus direct checks on request timing, backpressure, reset and stray-ack counting.
module tb_cfg_req_initiator;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] stray_ack_cnt;

    cfg_req_initiator_if bus ();

    cfg_req_initiator #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .stray_ack_cnt (stray_ack_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  status;
        logic [63:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_rsp    = 0;

    task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [68:0] mk_ack(input logic rv, input logic rm, input logic wv,
                                           input logic wm, input logic sai, input logic [63:0] d);
        return {wv, rv, d, rm, wm, sai};
    endfunction

    function automatic logic [143:0] mk_req(input logic v, input logic [3:0] op, input logic [47:0] a,
                                            input logic [7:0] be, input logic [63:0] d,
                                            input logic [7:0] sai, input logic [7:0] fid,
                                            input logic [2:0] bar);
        return {v, op, a, be, d, sai, fid, bar};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            rsp_t e;
            n_rsp++;
            check_eq("sb_nonempty", 144'(sb.size() != 0), 144'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("rsp_status", 144'(bus.rsp_status), 144'(e.status));
                check_eq("rsp_data", 144'(bus.rsp_data), 144'(e.data));
            end
            $display("rsp #%0d status=%0d data=0x%016h", n_rsp, bus.rsp_status, bus.rsp_data);
        end
    end

    // k = cycles from req.valid to ack (0 = never ack, expect timeout).
    task automatic do_txn(input logic [3:0] op, input logic [47:0] addr, input logic [7:0] be,
                          input logic [63:0] data, input int k, input logic [68:0] ackv,
                          input logic [2:0] est, input logic [63:0] edata);
        logic [143:0] ereq;
        logic [7:0]   sai;
        logic [7:0]   fid;
        logic [2:0]   bar;
        int           n;
        sai = 8'h5A ^ {4'd0, op};
        fid = 8'h30 + {4'd0, op};
        bar = op[2:0];
        check_eq("cmd_ready_idle", 144'(bus.cmd_ready), 144'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_addr   = addr;
        bus.cmd_be     = be;
        bus.cmd_data   = data;
        bus.cmd_sai    = sai;
        bus.cmd_fid    = fid;
        bus.cmd_bar    = bar;
        sb.push_back('{est, edata});
        tick();
        bus.cmd_valid = 1'b0;
        $display("cmd op=0x%0h addr=0x%0h k=%0d exp_status=%0d", op, addr, k, est);
        if (op[3]) begin
            check_eq("req_valid_illegal", 144'(bus.req[143]), 144'd0);
            check_eq("rsp_valid_illegal_t1", 144'(bus.rsp_valid), 144'd1);
        end else begin
            ereq = mk_req(1'b1, op, addr, be, data, sai, fid, bar);
            check_eq("req_issue", bus.req, ereq);
            ereq[143] = 1'b0;
            if (k > 0) begin
                for (int i = 0; i < k; i++) begin
                    tick();
                    check_eq("req_wait_hold", bus.req, ereq);
                    check_eq("rsp_valid_early", 144'(bus.rsp_valid), 144'd0);
                end
                bus.ack = ackv;
                tick();
                bus.ack = '0;
                check_eq("rsp_valid_latency", 144'(bus.rsp_valid), 144'd1);
            end else begin
                n = 0;
                while (!bus.rsp_valid && n < 100) begin
                    tick();
                    n++;
                end
                check_eq("timeout_cycles", 144'(n), 144'(TIMEOUT + 1));
            end
        end
        if (bus.rsp_ready) begin
            tick();
            check_eq("rsp_valid_drop", 144'(bus.rsp_valid), 144'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_before;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_addr = '0; bus.cmd_be = '0;
        bus.cmd_data = '0; bus.cmd_sai = '0; bus.cmd_fid = '0; bus.cmd_bar = '0;
        bus.ack = '0; bus.rsp_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_cmd_ready", 144'(bus.cmd_ready), 144'd0);
        check_eq("rst_req", bus.req, 144'd0);
        check_eq("rst_rsp_valid", 144'(bus.rsp_valid), 144'd0);
        check_eq("rst_rsp_data", 144'(bus.rsp_data), 144'd0);
        check_eq("rst_rsp_status", 144'(bus.rsp_status), 144'd0);
        check_eq("rst_stray", 144'(stray_ack_cnt), 144'd0);
        rst_n = 1'b1;
        tick();

        // Read OK, write miss, write SAI fail, write OK, read miss.
        do_txn(4'd4, 48'h000000000100, 8'hFF, 64'd0, 3,
               mk_ack(1, 0, 0, 0, 1, 64'hDEADBEEF_CAFEF00D), 3'd0, 64'hDEADBEEF_CAFEF00D);
        do_txn(4'd1, 48'h000000000200, 8'hFF, 64'h1234, 1,
               mk_ack(0, 0, 0, 1, 1, 64'h55), 3'd1, 64'd0);
        do_txn(4'd1, 48'h000000000208, 8'hFF, 64'h1234, 2,
               mk_ack(0, 0, 1, 0, 0, 64'h66), 3'd2, 64'd0);
        do_txn(4'd3, 48'h0000ABCD0010, 8'h0F, 64'h77, 5,
               mk_ack(0, 0, 1, 0, 1, 64'hFFFF), 3'd0, 64'd0);
        do_txn(4'd2, 48'h000000000300, 8'hFF, 64'd0, 2,
               mk_ack(0, 1, 0, 0, 1, 64'h99), 3'd1, 64'd0);

        // Timeout, then a late read_valid counted as stray with no response.
        do_txn(4'd6, 48'h000000000400, 8'hFF, 64'd0, 0, '0, 3'd3, 64'd0);
        rsp_before = n_rsp;
        bus.ack = mk_ack(1, 0, 0, 0, 1, 64'h1);
        tick();
        bus.ack = '0;
        repeat (3) tick();
        check_eq("late_ack_stray", 144'(stray_ack_cnt), 144'd1);
        check_eq("late_ack_no_rsp", 144'(n_rsp), 144'(rsp_before));

        // Illegal opcode, protocol errors, and an ack coinciding with timer expiry.
        do_txn(4'hA, 48'h000000000500, 8'hFF, 64'd0, 0, '0, 3'd5, 64'd0);
        do_txn(4'd4, 48'h000000000600, 8'hFF, 64'd0, 1,
               mk_ack(0, 0, 1, 0, 1, 64'h1), 3'd4, 64'd0);
        do_txn(4'd0, 48'h000000000700, 8'hFF, 64'd0, 4,
               mk_ack(1, 1, 0, 0, 1, 64'h1), 3'd4, 64'd0);
        do_txn(4'd4, 48'h000000000800, 8'hFF, 64'd0, TIMEOUT,
               mk_ack(1, 0, 0, 0, 1, 64'h0123456789ABCDEF), 3'd0, 64'h0123456789ABCDEF);

        // Backpressure: response held, new command refused.
        bus.rsp_ready = 1'b0;
        do_txn(4'd4, 48'h000000000900, 8'hFF, 64'd0, 1,
               mk_ack(1, 0, 0, 0, 1, 64'hA5A5A5A5_5A5A5A5A), 3'd0, 64'hA5A5A5A5_5A5A5A5A);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 4'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("bp_rsp_valid", 144'(bus.rsp_valid), 144'd1);
            check_eq("bp_rsp_data", 144'(bus.rsp_data), 144'h00A5A5A5A5_5A5A5A5A);
            check_eq("bp_rsp_status", 144'(bus.rsp_status), 144'd0);
            check_eq("bp_cmd_ready", 144'(bus.cmd_ready), 144'd0);
            check_eq("bp_no_req", 144'(bus.req[143]), 144'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        check_eq("bp_release", 144'(bus.rsp_valid), 144'd0);

        // Reset during WAIT abandons the transaction.
        rsp_before = n_rsp;
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 4'd4; bus.cmd_addr = 48'h0A00;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("midrst_req", bus.req, 144'd0);
        check_eq("midrst_rsp_valid", 144'(bus.rsp_valid), 144'd0);
        check_eq("midrst_cmd_ready", 144'(bus.cmd_ready), 144'd0);
        check_eq("midrst_stray", 144'(stray_ack_cnt), 144'd0);
        rst_n = 1'b1;
        repeat (TIMEOUT + 10) tick();
        check_eq("midrst_no_rsp", 144'(n_rsp), 144'(rsp_before));
        check_eq("midrst_idle", 144'(bus.cmd_ready), 144'd1);

        // Stray-ack saturation.
        bus.ack = mk_ack(1, 0, 0, 0, 0, 64'd0);
        repeat (300) tick();
        bus.ack = '0;
        check_eq("stray_saturate", 144'(stray_ack_cnt), 144'd255);
        $display("stray ack burst done cnt=%0d", stray_ack_cnt);

        tick();
        check_eq("sb_drained", 144'(sb.size()), 144'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
